// File: rtl/fifo_pkg.sv
// Shared FIFO sizing constants for the transaction-layer transmit and receive queues.
package fifo_pkg;
    localparam int DATA_WIDTH          = 12;
    localparam int ADDR_WIDTH          = 3;
    localparam int DEPTH               = 1 << ADDR_WIDTH;
    localparam int ALMOST_FULL_TH_DEF  = 6;
    localparam int ALMOST_EMPTY_TH_DEF = 2;
endpackage

// File: rtl/fifo_dpram_ctrl_if.sv
// Push/pop queue bus. The master is the producer/consumer side; the slave is the FIFO.
interface fifo_dpram_ctrl_if import fifo_pkg::*; #(
    parameter int DW = DATA_WIDTH,
    parameter int AW = ADDR_WIDTH
) ();
    logic          push;
    logic [DW-1:0] data_in;
    logic          pop;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          fifo_error;

    modport master (
        output push, data_in, pop,
        input  data_out, valid_out, count, full, empty, almost_full, almost_empty, fifo_error
    );

    modport slave (
        input  push, data_in, pop,
        output data_out, valid_out, count, full, empty, almost_full, almost_empty, fifo_error
    );
endinterface

// File: rtl/true_dpram_sclk.sv
// Single-clock true dual-port RAM, registered reads on both ports, read-before-write.
// One cycle read latency; no flow control, contents are not reset.
module true_dpram_sclk #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] q_b
);
    logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

    // Reads return the old word when the other port writes the same address.
    always_ff @(posedge clk) begin
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
        if (we_a) mem[addr_a] <= data_a;
        if (we_b) mem[addr_b] <= data_b;
    end
endmodule

// File: rtl/fifo_dpram_ctrl.sv
// Synchronous FIFO controller over true_dpram_sclk: port A writes, port B reads.
// Pop-to-data latency 1 cycle; full push without pop and empty pop are dropped with a fifo_error pulse.
module fifo_dpram_ctrl import fifo_pkg::*; #(
    parameter int DATA_WIDTH      = fifo_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH      = fifo_pkg::ADDR_WIDTH,
    parameter int ALMOST_FULL_TH  = ALMOST_FULL_TH_DEF,
    parameter int ALMOST_EMPTY_TH = ALMOST_EMPTY_TH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    fifo_dpram_ctrl_if.slave  bus
);
    localparam int CW  = ADDR_WIDTH + 1;
    localparam int DEP = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  full, empty;
    logic                  push_acc, pop_acc;
    logic [DATA_WIDTH-1:0] q_b;
    logic [DATA_WIDTH-1:0] unused_q_a;

    always_comb begin
        full     = (count_q == CW'(DEP));
        empty    = (count_q == '0);
        // A pop frees a slot in the same cycle, so a full FIFO still takes a push paired with a pop.
        pop_acc  = bus.pop & ~empty & ~reset;
        push_acc = bus.push & (~full | pop_acc) & ~reset;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = pop_acc;
        err_d    = (bus.push & ~push_acc) | (bus.pop & ~pop_acc);
        if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    true_dpram_sclk #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk    (clk),
        .we_a   (push_acc),
        .addr_a (wr_ptr_q),
        .data_a (bus.data_in),
        .q_a    (unused_q_a),
        .we_b   (1'b0),
        .addr_b (rd_ptr_q),
        .data_b ('0),
        .q_b    (q_b)
    );

    assign bus.data_out     = valid_q ? q_b : '0;
    assign bus.valid_out    = valid_q;
    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CW'(ALMOST_FULL_TH));
    assign bus.almost_empty = (count_q <= CW'(ALMOST_EMPTY_TH));
    assign bus.fifo_error   = err_q;
endmodule

// File: tb/tb_fifo_dpram_ctrl.sv
// Directed bench for fifo_dpram_ctrl with a popped-word scoreboard checked by a negedge monitor.
module tb_fifo_dpram_ctrl;
    import fifo_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fifo_dpram_ctrl_if bus ();

    fifo_dpram_ctrl #(
        .DATA_WIDTH      (12),
        .ADDR_WIDTH      (3),
        .ALMOST_FULL_TH  (6),
        .ALMOST_EMPTY_TH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [11:0] ref_q [$];
    logic [11:0] exp_q [$];

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle; on an accepted pop the oldest stored word becomes the expected output.
    task automatic step(input bit p, input logic [11:0] d, input bit q);
        bit pa, wa;
        bus.push    = p;
        bus.data_in = d;
        bus.pop     = q;
        @(posedge clk);
        pa = q && (ref_q.size() > 0);
        wa = p && ((ref_q.size() < 8) || pa);
        if (pa) exp_q.push_back(ref_q.pop_front());
        if (wa) ref_q.push_back(d);
        #1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;
    endtask

    task automatic chk_status(input string name, input int c, input bit e);
        cmp({name, ".count"},        int'(bus.count),        c);
        cmp({name, ".full"},         int'(bus.full),         int'(c == 8));
        cmp({name, ".empty"},        int'(bus.empty),        int'(c == 0));
        cmp({name, ".almost_full"},  int'(bus.almost_full),  int'(c >= 6));
        cmp({name, ".almost_empty"}, int'(bus.almost_empty), int'(c <= 2));
        cmp({name, ".fifo_error"},   int'(bus.fifo_error),   int'(e));
    endtask

    task automatic do_reset(input bit with_pop);
        reset       = 1'b1;
        bus.push    = 1'b1;
        bus.data_in = 12'hFFF;
        bus.pop     = with_pop;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        ref_q.delete();
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (exp_q.size() > 0) begin
                logic [11:0] w;
                w = exp_q.pop_front();
                cmp("mon.valid_out", int'(bus.valid_out), 1);
                cmp("mon.data_out",  int'(bus.data_out),  int'(w));
            end else begin
                cmp("mon.idle_valid_out", int'(bus.valid_out), 0);
                cmp("mon.idle_data_out",  int'(bus.data_out),  0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;
        @(posedge clk);
        do_reset(1'b1);
        chk_status("reset", 0, 1'b0);
        cmp("reset.valid_out", int'(bus.valid_out), 0);
        cmp("reset.data_out",  int'(bus.data_out),  0);

        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 12'(i), 1'b0);
            chk_status($sformatf("fill%0d", i), i, 1'b0);
        end

        step(1'b1, 12'hABC, 1'b0);
        chk_status("full_push", 8, 1'b1);
        step(1'b0, 12'h000, 1'b0);
        chk_status("full_push_after", 8, 1'b0);

        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 12'h000, 1'b1);
            chk_status($sformatf("drain%0d", i), 8 - i, 1'b0);
        end

        step(1'b1, 12'h055, 1'b1);
        chk_status("empty_push_pop", 1, 1'b1);
        step(1'b0, 12'h000, 1'b1);
        chk_status("pop_055", 0, 1'b0);

        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 12'(12'h200 + i), 1'b0);
        end
        chk_status("refill", 8, 1'b0);
        step(1'b1, 12'h111, 1'b1);
        chk_status("full_push_pop", 8, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 12'h000, 1'b1);
        end
        chk_status("wrap_drain", 0, 1'b0);

        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 12'(12'h300 + i), 1'b0);
        end
        chk_status("five", 5, 1'b0);
        do_reset(1'b1);
        chk_status("mid_reset", 0, 1'b0);
        cmp("mid_reset.valid_out", int'(bus.valid_out), 0);
        cmp("mid_reset.data_out",  int'(bus.data_out),  0);
        step(1'b0, 12'h000, 1'b1);
        chk_status("pop_after_reset", 0, 1'b1);
        cmp("pop_after_reset.valid_out", int'(bus.valid_out), 0);

        step(1'b0, 12'h000, 1'b0);
        step(1'b0, 12'h000, 1'b0);
        cmp("scoreboard_pending", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_dpram_ctrl.md
# fifo_dpram_ctrl

Synchronous FIFO controller that owns both ports of the `true_dpram_sclk` 8x12 dual-port RAM. Port A is the write side and port B is the read side. It gives the transaction layer a push/pop queue with full, empty, almost-full and almost-empty flags, an occupancy count, and an error pulse. It sits between a TLP producer and a consumer as the standard buffering element of the layer.

## Interface
- `DATA_WIDTH`, 12, word width; must match the RAM.
- `ADDR_WIDTH`, 3, RAM address width; depth is 2^ADDR_WIDTH = 8.
- `ALMOST_FULL_TH`, 6, `almost_full` asserts when count >= this value.
- `ALMOST_EMPTY_TH`, 2, `almost_empty` asserts when count <= this value.
- `clk`  in  1  single clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `push`  in  1  write request for `data_in` this cycle.
- `data_in`  in  DATA_WIDTH  word to enqueue.
- `pop`  in  1  read request this cycle.
- `data_out`  out  DATA_WIDTH  dequeued word; 0 whenever `valid_out` = 0.
- `valid_out`  out  1  `data_out` holds a popped word this cycle.
- `count`  out  ADDR_WIDTH+1  occupancy, 0..8.
- `full`, `empty`, `almost_full`, `almost_empty`  out  1 each  status flags.
- `fifo_error`  out  1  one-cycle pulse on a rejected push or pop.

## Operation
- Registers: `wr_ptr`, `rd_ptr` (ADDR_WIDTH bits, wrap 7 -> 0 by natural overflow) and `count` (ADDR_WIDTH+1 bits).
- Flags are decoded combinationally from the `count` register:
  - `full` = (count == 8)
  - `empty` = (count == 0)
  - `almost_full` and `almost_empty` compare `count` against their thresholds.
- Accepted push is `push & (~full | pop_acc)`:
  - drives `we_a` = 1, `addr_a` = `wr_ptr`, `data_a` = `data_in`;
  - `wr_ptr` increments.
- Accepted pop (`pop_acc`) is `pop & ~empty`:
  - drives `addr_b` = `rd_ptr`, `we_b` = 0;
  - `rd_ptr` increments.
- Port B never writes, and port A's read data is unused.
- `count` update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop:
  - When full: both are accepted and `count` stays 8.
  - When empty: the push is accepted, the pop is rejected with `fifo_error`, and `count` becomes 1.
  - Otherwise: both are accepted. The pointers differ, so there is no RAM address collision.
- Rejected operations:
  - Push when full with no pop: word dropped, pointers unchanged, `fifo_error` = 1 for one cycle.
  - Pop when empty: `fifo_error` = 1 for one cycle, `valid_out` stays 0.
- Reset, at power-up or mid-operation:
  - pointers = 0, `count` = 0, `empty` = 1, `almost_empty` = 1, `full` = 0, `almost_full` = 0, `valid_out` = 0, `data_out` = 0, `fifo_error` = 0;
  - RAM contents are not cleared but become unreachable;
  - push and pop asserted in the reset cycle are ignored.

## Timing
- Pop accepted at edge N: `valid_out` = 1 and `data_out` = word from cycle N+1. The RAM read is registered, so `valid_out` is a 1-cycle delayed copy of `pop_acc`.
- Push at edge N: the word is written at edge N. A pop issued in the cycle after N may return it (first-word latency of 2 cycles from push to `data_out`).
- `count` and the flags reflect all operations accepted at edge N during cycle N+1.
- `fifo_error` is registered and is high for the cycle after the offending edge.
- Back-to-back pops stream one word per cycle with no bubbles.

## Structure
- Shared package `fifo_pkg`: `DATA_WIDTH`, `ADDR_WIDTH`, derived `DEPTH` and default threshold constants, reused by the transmit and receive queues.
- The only sub-module is `true_dpram_sclk`, instantiated as `u_mem`. The controller contains pointers, count, flag decode and error/valid registers only.

## Test plan
- Reset then push 0x001..0x008 on consecutive cycles:
  - `count` climbs 1..8;
  - `almost_full` rises at count 6;
  - `full` = 1 after the 8th push.
- From full, pop 8 times: `data_out` = 0x001..0x008 on consecutive cycles with `valid_out` = 1; `empty` = 1 and `almost_empty` = 1 at the end.
- Full plus push 0xABC with no pop: `fifo_error` pulses once, `count` stays 8, and a later drain never returns 0xABC.
- Empty plus push 0x055 and pop together: `fifo_error` pulses, `count` = 1, and the next pop returns 0x055.
- Full plus push 0x111 and pop together: the oldest word is returned, `count` stays 8, and 0x111 is the last word drained (wrap-around of both pointers).
- Push 5 words, then assert `reset` for 1 cycle while popping: all outputs take their reset values, and a following pop gives `fifo_error` with no `valid_out`.
